// File: rtl/fpga_template_rb_spi.sv
`default_nettype none
// ============================================================================
// Module      : fpga_template_rb_spi
// Description : SPI mode-0 slave register bank, oversampled by clk
// Revision    : 1.0 - initial release
// ============================================================================
// sys_cfg packing: [16] enable_stuf, [15] enable_other, [14] monitor_flag,
//                  [13:6] pwm_duty, [5:0] debug_led
module fpga_template_rb_spi #(
    parameter logic [7:0] CHIP_ID = 8'hA5
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        spi_csn,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic        monitor_flag_i,
    output logic [16:0] sys_cfg,
    output logic [7:0]  dsp_cfg,
    output logic        wr_strobe,
    output logic [6:0]  wr_addr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_csn_s, r_sclk_s, r_mosi_s;
    logic        r_sclk_prev, r_csn_prev;
    logic [1:0]  r_settle;
    logic        r_armed;
    logic [3:0]  r_bit_cnt;
    logic [6:0]  r_shift;
    logic        r_rw;
    logic [6:0]  r_addr;
    logic [6:0]  r_rd_shift;
    logic        r_miso;
    logic        r_wr_strobe;
    logic [6:0]  r_wr_addr;
    logic        r_enable_stuf, r_enable_other;
    logic [7:0]  r_pwm_duty;
    logic [5:0]  r_debug_led;
    logic [7:0]  r_dsp_cfg;

    logic        w_csn, w_mosi, w_sclk_rise, w_sclk_fall, w_csn_fall;
    logic        w_commit, w_rd_load, w_rd_shift;
    logic [7:0]  w_wdata, w_rd_data;

    assign w_csn       = r_csn_s[1];
    assign w_mosi      = r_mosi_s[1];
    assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_prev;
    assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_prev;
    assign w_csn_fall  = r_csn_prev & ~w_csn;
    assign w_wdata     = {r_shift, w_mosi};
    assign w_commit    = (r_state == ST_DATA) && w_sclk_rise && (r_bit_cnt == 4'd15)
                         && !w_csn && r_rw;
    assign w_rd_load   = (r_state == ST_DATA) && w_sclk_fall && (r_bit_cnt == 4'd8) && !r_rw;
    assign w_rd_shift  = (r_state == ST_DATA) && w_sclk_fall && (r_bit_cnt > 4'd8) && !r_rw;

    always_comb begin
        w_rd_data = 8'h00;
        case (r_addr)
            7'h00:   w_rd_data = {5'b0, monitor_flag_i, r_enable_other, r_enable_stuf};
            7'h01:   w_rd_data = r_pwm_duty;
            7'h02:   w_rd_data = {2'b0, r_debug_led};
            7'h03:   w_rd_data = r_dsp_cfg;
            7'h7F:   w_rd_data = CHIP_ID;
            default: w_rd_data = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_csn) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_csn_fall && r_armed) w_state_nxt = ST_CMD;
                ST_CMD:  if (w_sclk_rise && r_bit_cnt == 4'd7) w_state_nxt = ST_DATA;
                ST_DATA: if (w_sclk_rise && r_bit_cnt == 4'd15) w_state_nxt = ST_DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_csn_s        <= 2'b11;
            r_sclk_s       <= 2'b00;
            r_mosi_s       <= 2'b00;
            r_sclk_prev    <= 1'b0;
            r_csn_prev     <= 1'b1;
            r_settle       <= 2'b00;
            r_armed        <= 1'b0;
            r_bit_cnt      <= 4'd0;
            r_shift        <= 7'd0;
            r_rw           <= 1'b0;
            r_addr         <= 7'd0;
            r_rd_shift     <= 7'd0;
            r_miso         <= 1'b0;
            r_wr_strobe    <= 1'b0;
            r_wr_addr      <= 7'd0;
            r_enable_stuf  <= 1'b0;
            r_enable_other <= 1'b0;
            r_pwm_duty     <= 8'h80;
            r_debug_led    <= 6'd0;
            r_dsp_cfg      <= 8'h80;
        end else begin
            r_csn_s     <= {r_csn_s[0], spi_csn};
            r_sclk_s    <= {r_sclk_s[0], spi_sclk};
            r_mosi_s    <= {r_mosi_s[0], spi_mosi};
            r_sclk_prev <= r_sclk_s[1];
            r_csn_prev  <= w_csn;
            // Arm only once the synchronizer holds a real csn-high sample, so a
            // frame interrupted by reset is not mistaken for a new one.
            r_settle    <= {r_settle[0], 1'b1};
            r_armed     <= r_armed | (r_settle[1] & w_csn);
            r_wr_strobe <= 1'b0;

            if (r_state == ST_IDLE) begin
                r_bit_cnt <= 4'd0;
            end else if ((r_state == ST_CMD || r_state == ST_DATA) && w_sclk_rise) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_shift   <= {r_shift[5:0], w_mosi};
            end

            if (r_state == ST_CMD && w_sclk_rise && r_bit_cnt == 4'd7) begin
                r_rw   <= r_shift[6];
                r_addr <= {r_shift[5:0], w_mosi};
            end

            if (w_commit) begin
                r_wr_strobe <= 1'b1;
                r_wr_addr   <= r_addr;
                case (r_addr)
                    7'h00: begin
                        r_enable_stuf  <= w_wdata[0];
                        r_enable_other <= w_wdata[1];
                    end
                    7'h01:   r_pwm_duty  <= w_wdata;
                    7'h02:   r_debug_led <= w_wdata[5:0];
                    7'h03:   r_dsp_cfg   <= w_wdata;
                    default: ;
                endcase
            end

            if (w_state_nxt != ST_DATA) begin
                r_miso <= 1'b0;
            end else if (w_rd_load) begin
                r_miso     <= w_rd_data[7];
                r_rd_shift <= w_rd_data[6:0];
            end else if (w_rd_shift) begin
                r_miso     <= r_rd_shift[6];
                r_rd_shift <= {r_rd_shift[5:0], 1'b0};
            end
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = ~w_csn;
    assign sys_cfg     = {r_enable_stuf, r_enable_other, monitor_flag_i, r_pwm_duty, r_debug_led};
    assign dsp_cfg     = r_dsp_cfg;
    assign wr_strobe   = r_wr_strobe;
    assign wr_addr     = r_wr_addr;

endmodule
`default_nettype wire

// File: doc/fpga_template_rb_spi.md
FPGA_TEMPLATE_RB_SPI -- requirements
Module: fpga_template_rb_spi

Interface
REQ-001 Parameter: CHIP_ID, default 8'hA5, value returned by reads of address 0x7F.
REQ-002 clk  in  1  system clock; the only clock.
REQ-003 resetb  in  1  reset; synchronous, active-low; sampled on rising clk.
REQ-004 spi_csn  in  1  chip select, active-low, asynchronous to clk.
REQ-005 spi_sclk  in  1  serial clock, asynchronous to clk; clk frequency >= 8x sclk.
REQ-006 spi_mosi  in  1  serial data in.
REQ-007 spi_miso  out  1  serial data out.
REQ-008 spi_miso_oe  out  1  miso output enable; 1 while synchronized csn is low.
REQ-009 monitor_flag_i  in  1  internal flag; readable at 0x00 bit2.
REQ-010 sys_cfg  out  17  fpga_template_pkg::rb_sys_cfg_wire_t.
REQ-011 dsp_cfg  out  8  fpga_template_pkg::rb_dsp_cfg_wire_t.
REQ-012 wr_strobe  out  1  one-clk pulse per committed write.
REQ-013 wr_addr  out  7  address of the last committed write.

Function
REQ-014 csn, sclk and mosi each pass through a 2-flop synchronizer; sclk edges are detected from the synchronized value and its previous value.
REQ-015 Frame: SPI mode 0, MSB first, 16 bits: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-016 mosi is sampled on detected rising sclk edges; miso changes only on detected falling sclk edges.
REQ-017 FSM states: IDLE, CMD, DATA, DONE.
- IDLE -> CMD on synchronized csn falling; 4-bit bit counter cleared.
- CMD -> DATA after the 8th rising edge.
- DATA -> DONE after the 16th rising edge.
- DONE ignores all sclk edges.
- Any state -> IDLE when synchronized csn is high.
REQ-018 Write commit: on the clk cycle after the 16th rising edge is detected, the addressed register loads bits7:0, wr_strobe = 1 for exactly one cycle and wr_addr updates.
REQ-019 Register map:
- 0x00: bit0 enable_stuf, bit1 enable_other, bit2 monitor_flag (read-only).
- 0x01: pwm_duty[7:0].
- 0x02: debug_led[5:0]; bits7:6 read 0.
- 0x03: dsp_cfg[7:0], bypass_enable = bit7 through placeholder3 = bit0.
- 0x7F: CHIP_ID, read-only.
REQ-020 Writes to read-only bits or unmapped addresses are discarded; wr_strobe still pulses.
REQ-021 Reads of unmapped addresses return 0x00.
REQ-022 Read: on the 8th falling edge, the read shift register loads the addressed value, sampled in that cycle; bits 7..0 are driven on miso across frame bits 8..15.
REQ-023 miso = 0 during CMD, in IDLE and in DONE.
REQ-024 During a write frame miso = 0.
REQ-025 sys_cfg.monitor_flag follows monitor_flag_i combinationally.
REQ-026 All other sys_cfg and dsp_cfg fields are driven directly from register flops.
REQ-027 csn rising before 16 rising edges aborts the frame: no commit, no wr_strobe, registers unchanged.
REQ-028 More than 16 sclk rising edges within one csn-low window: extra edges are ignored; exactly one commit.
REQ-029 A new frame needs csn high for at least 3 clk cycles; back-to-back frames commit independently.

Reset
REQ-030 When resetb = 0 at a rising clk edge, on that edge:
- FSM -> IDLE; bit counter and shift registers cleared.
- spi_miso = 0, wr_strobe = 0, wr_addr = 0.
- enable_stuf = 0, enable_other = 0, pwm_duty = 0x80, debug_led = 0.
- dsp_cfg = 8'h80 (bypass_enable = 1, others 0).
- Synchronizer flops: csn stages = 1, sclk and mosi stages = 0.
REQ-031 Reset mid-frame discards the frame; after reset, the first frame is recognized only after a fresh csn falling edge.

Verification
REQ-032 Reset, then read 0x01, 0x03 and 0x7F -> returns 0x80, 0x80 and 0xA5; outputs equal the reset values.
REQ-033 Write 0x01 <- 0x3C -> pwm_duty = 0x3C; one wr_strobe pulse with wr_addr = 0x01; read-back = 0x3C.
REQ-034 Write 0x00 <- 0xFF with monitor_flag_i = 0, then read 0x00 -> returns 0x03; raise monitor_flag_i and read again -> returns 0x07.
REQ-035 Write 0x02 <- 0x2A with csn raised after 12 bits -> debug_led stays 0; no wr_strobe.
REQ-036 Write 0x03 <- 0x5A with 20 sclk pulses -> dsp_cfg = 0x5A; exactly one wr_strobe; then read 0x55 -> returns 0x00.
REQ-037 Assert resetb low during the DATA phase of a write 0x01 <- 0x11 -> pwm_duty = 0x80; the next full frame operates normally.
